te_ingress_rx: RTL and testbench
================================

Name: te_ingress_rx

Overview:
- Receiving end of the E-trace ingress interface that complex_fsm drives.
- Captures each valid N-block ingress bundle (iretire/ilastsize/itype/cause/tval/priv/iaddr) into a DEPTH-entry bundle FIFO.
- Serializes the non-empty blocks one per cycle to the downstream packet encoder over a valid/ready handshake.
- The producer has no ready, so loss on full is detected and flagged.

Parameters:
- N, 2, ingress blocks per bundle; must match complex_fsm N.
- DEPTH, 4, bundle FIFO entries; power of two, at least 2.
- Widths XLEN, IRETIRE_LEN, ITYPE_LEN, CAUSE_LEN, PRIV_LEN come from mure_pkg.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- valid_i  in  1  ingress bundle valid.
- iretire_i  in  N x IRETIRE_LEN  per-block retired half-word count.
- ilastsize_i  in  N  per-block last instruction size.
- itype_i  in  N x ITYPE_LEN  per-block instruction type.
- cause_i  in  N x CAUSE_LEN  per-block exception/interrupt cause.
- tval_i  in  N x XLEN  per-block trap value.
- priv_i  in  N x PRIV_LEN  per-block privilege.
- iaddr_i  in  N x XLEN  per-block first instruction address.
- valid_o  out  1  output block valid.
- ready_i  in  1  downstream accepts block.
- iretire_o, ilastsize_o, itype_o, cause_o, tval_o, priv_o, iaddr_o  out  single-block widths  selected block fields.
- block_idx_o  out  $clog2(N) (min 1)  source index of the presented block.
- last_o  out  1  presented block is the last non-empty block of its bundle.
- overflow_o  out  1  sticky: a bundle was dropped.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Empty block: iretire==0 and itype==0.
- Write side: push iff valid_i, at least one non-empty block, and (not full, or a pop occurs in the same cycle).
  - All-empty bundles are discarded silently; overflow_o is not set.
  - valid_i while full with no pop: bundle dropped, overflow_o set.
  - overflow_o stays set until reset.
- FIFO: read/write pointers of log2(DEPTH)+1 bits, wrapping naturally. Full when MSBs differ and LSBs are equal. Empty when the pointers are equal.
- Read side:
  - valid_o = FIFO not empty.
  - The output fields are the head bundle's block at cur_idx; block_idx_o = cur_idx.
- cur_idx is always the lowest non-empty block index at or above the previous emission point.
  - On entry to a new head bundle, cur_idx = lowest non-empty index (priority encode, LSB first).
  - last_o = no non-empty block above cur_idx in the head bundle.
- Handshake: a transfer occurs when valid_o and ready_i are both high.
  - Transfer with last_o=0: cur_idx advances to the next non-empty index above it.
  - Transfer with last_o=1: the head is popped and cur_idx is recomputed for the new head.
  - While valid_o=1 and ready_i=0, all outputs stay stable.
- Latency: a bundle pushed in cycle t is presented at cycle t+1 if the FIFO was empty. Throughput is one block per cycle.
- Simultaneous push and pop while full is allowed and leaves occupancy unchanged.
- Reset values: valid_o=0, all data outputs 0, block_idx_o=0, last_o=0, overflow_o=0; pointers 0, cur_idx 0.
- Reset mid-operation discards every stored bundle and any partially emitted bundle.
- Data outputs are forced to 0 when valid_o=0.

Optional Feature:
- Macro: TE_INGRESS_DROP_CNT_EN.
- When defined:
  - Adds output drop_cnt_o (16 bits), counting dropped bundles. It saturates at 0xFFFF and resets to 0.
  - Adds input drop_cnt_clr_i (1 bit), which zeroes the counter next cycle. On a simultaneous drop, clear wins.
- When undefined: neither port exists, and only the sticky overflow_o reports loss.

Test Plan:
- Single bundle, N=2, both blocks non-empty (iretire 3/5, iaddr 0x80000000/0x80000010), ready_i=1:
  - block_idx 0 presented at t+1 with last_o=0; block_idx 1 at t+2 with last_o=1.
  - valid_o=0 at t+3.
- Bundle with block 0 empty and block 1 itype=1 (exception), cause=2, tval=0xDEAD: a single beat with block_idx_o=1, last_o=1, cause_o=2, tval_o=0xDEAD.
- All-empty bundle: no push, valid_o stays 0, overflow_o stays 0.
- ready_i=0 with 5 consecutive valid bundles:
  - The first 4 are stored, the 5th sets overflow_o=1.
  - After ready_i=1, exactly 4 bundles are emitted in order, and overflow_o remains 1.
- Full FIFO with a push in the same cycle as the last-block transfer: push accepted, overflow_o stays 0, occupancy stays 4.
- rst_i asserted between the two beats of a bundle: next cycle valid_o=0 and overflow_o=0; a new bundle after reset emits from block_idx 0.

Source files
------------

// File: rtl/mure_pkg.sv
// Shared trace widths and the per-block ingress payload.
package mure_pkg;

   localparam int unsigned XLEN        = 32;
   localparam int unsigned IRETIRE_LEN = 14;
   localparam int unsigned ITYPE_LEN   = 4;
   localparam int unsigned CAUSE_LEN   = 5;
   localparam int unsigned PRIV_LEN    = 2;

   typedef struct packed {
      logic [IRETIRE_LEN-1:0] iretire;
      logic                   ilastsize;
      logic [ITYPE_LEN-1:0]   itype;
      logic [CAUSE_LEN-1:0]   cause;
      logic [XLEN-1:0]        tval;
      logic [PRIV_LEN-1:0]    priv;
      logic [XLEN-1:0]        iaddr;
   } te_block_t;

endpackage

// File: rtl/te_ingress_rx_if.sv
// Ingress bundle bus plus serialized single-block egress handshake for te_ingress_rx.
interface te_ingress_rx_if #(
   parameter int unsigned N = 2
) ();

   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

   logic                                       valid_i;
   logic [N-1:0][mure_pkg::IRETIRE_LEN-1:0]    iretire_i;
   logic [N-1:0]                               ilastsize_i;
   logic [N-1:0][mure_pkg::ITYPE_LEN-1:0]      itype_i;
   logic [N-1:0][mure_pkg::CAUSE_LEN-1:0]      cause_i;
   logic [N-1:0][mure_pkg::XLEN-1:0]           tval_i;
   logic [N-1:0][mure_pkg::PRIV_LEN-1:0]       priv_i;
   logic [N-1:0][mure_pkg::XLEN-1:0]           iaddr_i;

   logic                                       valid_o;
   logic                                       ready_i;
   logic [mure_pkg::IRETIRE_LEN-1:0]           iretire_o;
   logic                                       ilastsize_o;
   logic [mure_pkg::ITYPE_LEN-1:0]             itype_o;
   logic [mure_pkg::CAUSE_LEN-1:0]             cause_o;
   logic [mure_pkg::XLEN-1:0]                  tval_o;
   logic [mure_pkg::PRIV_LEN-1:0]              priv_o;
   logic [mure_pkg::XLEN-1:0]                  iaddr_o;
   logic [IW-1:0]                              block_idx_o;
   logic                                       last_o;
   logic                                       overflow_o;

   modport master (
      output valid_i, iretire_i, ilastsize_i, itype_i, cause_i, tval_i, priv_i, iaddr_i,
      output ready_i,
      input  valid_o, iretire_o, ilastsize_o, itype_o, cause_o, tval_o, priv_o, iaddr_o,
      input  block_idx_o, last_o, overflow_o
   );

   modport slave (
      input  valid_i, iretire_i, ilastsize_i, itype_i, cause_i, tval_i, priv_i, iaddr_i,
      input  ready_i,
      output valid_o, iretire_o, ilastsize_o, itype_o, cause_o, tval_o, priv_o, iaddr_o,
      output block_idx_o, last_o, overflow_o
   );

endinterface

// File: rtl/te_ingress_rx.sv
// E-trace ingress receiver: buffers N-block bundles in a DEPTH-entry FIFO and emits non-empty blocks one per cycle.
// Optional drop counter (drop_cnt_o / drop_cnt_clr_i) enabled by TE_INGRESS_DROP_CNT_EN.
module te_ingress_rx
   import mure_pkg::*;
#(
   parameter int unsigned N     = 2,
   parameter int unsigned DEPTH = 4
) (
   input  logic               clk_i,
   input  logic               rst_i,
`ifdef TE_INGRESS_DROP_CNT_EN
   input  logic               drop_cnt_clr_i,
   output logic [15:0]        drop_cnt_o,
`endif
   te_ingress_rx_if.slave     bus
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

   function automatic logic [N-1:0] ne_mask(input te_block_t [N-1:0] bnd);
      logic [N-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < N; i++) begin
         m[i] = (bnd[i].iretire != '0) || (bnd[i].itype != '0);
      end
      return m;
   endfunction

   // Lowest set bit of m at or above index from; 0 when none.
   function automatic logic [IW-1:0] first_from(input logic [N-1:0] m, input int unsigned from);
      logic [IW-1:0] r;
      logic          found;
      r     = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (!found && m[i] && (i >= from)) begin
            r     = IW'(i);
            found = 1'b1;
         end
      end
      return r;
   endfunction

   function automatic logic any_above(input logic [N-1:0] m, input int unsigned cur);
      logic r;
      r = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (m[i] && (i > cur)) r = 1'b1;
      end
      return r;
   endfunction

   te_block_t [N-1:0] in_bnd;
   te_block_t [N-1:0] mem_q [DEPTH];

   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [IW-1:0]     cur_idx_q, cur_idx_d;
   logic              overflow_q, overflow_d;
   logic              valid_q, valid_d;
   te_block_t         blk_q, blk_d;
   logic [IW-1:0]     block_idx_q, block_idx_d;
   logic              last_q, last_d;

   logic              empty, full, xfer, pop, push, drop, nxt_empty;
   logic [N-1:0]      in_m, head_m, nxt_m;
   te_block_t [N-1:0] head, nxt_head;

   always_comb begin
      in_bnd = '0;
      for (int unsigned b = 0; b < N; b++) begin
         in_bnd[b].iretire   = bus.iretire_i[b];
         in_bnd[b].ilastsize = bus.ilastsize_i[b];
         in_bnd[b].itype     = bus.itype_i[b];
         in_bnd[b].cause     = bus.cause_i[b];
         in_bnd[b].tval      = bus.tval_i[b];
         in_bnd[b].priv      = bus.priv_i[b];
         in_bnd[b].iaddr     = bus.iaddr_i[b];
      end
   end

   // Next-state for pointers, block cursor and the registered output image of the next head.
   always_comb begin
      empty  = (wr_ptr_q == rd_ptr_q);
      full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      head   = mem_q[rd_ptr_q[AW-1:0]];
      head_m = ne_mask(head);
      in_m   = ne_mask(in_bnd);

      xfer = !empty && bus.ready_i;
      pop  = xfer && !any_above(head_m, 32'(cur_idx_q));
      push = bus.valid_i && (|in_m) && (!full || pop);
      drop = bus.valid_i && (|in_m) && full && !pop;

      wr_ptr_d   = wr_ptr_q + PW'(push);
      rd_ptr_d   = rd_ptr_q + PW'(pop);
      overflow_d = overflow_q | drop;
      nxt_empty  = (wr_ptr_d == rd_ptr_d);

      // A bundle written this cycle becomes the head when the read pointer lands on its slot.
      nxt_head = (push && (rd_ptr_d == wr_ptr_q)) ? in_bnd : mem_q[rd_ptr_d[AW-1:0]];
      nxt_m    = ne_mask(nxt_head);

      cur_idx_d = cur_idx_q;
      if (nxt_empty) begin
         cur_idx_d = '0;
      end else if (pop || empty) begin
         cur_idx_d = first_from(nxt_m, 0);
      end else if (xfer) begin
         cur_idx_d = first_from(nxt_m, 32'(cur_idx_q) + 1);
      end

      valid_d     = !nxt_empty;
      blk_d       = valid_d ? nxt_head[cur_idx_d] : '0;
      block_idx_d = valid_d ? cur_idx_d : '0;
      last_d      = valid_d && !any_above(nxt_m, 32'(cur_idx_d));
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cur_idx_q   <= '0;
         overflow_q  <= 1'b0;
         valid_q     <= 1'b0;
         blk_q       <= '0;
         block_idx_q <= '0;
         last_q      <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cur_idx_q   <= cur_idx_d;
         overflow_q  <= overflow_d;
         valid_q     <= valid_d;
         blk_q       <= blk_d;
         block_idx_q <= block_idx_d;
         last_q      <= last_d;
      end
   end

   // Bundle storage needs no reset: it is only observed through non-empty pointers.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= in_bnd;
   end

`ifdef TE_INGRESS_DROP_CNT_EN
   logic [15:0] drop_cnt_q, drop_cnt_d;

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (drop_cnt_clr_i) begin
         drop_cnt_d = '0;
      end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) drop_cnt_q <= '0;
      else       drop_cnt_q <= drop_cnt_d;
   end

   assign drop_cnt_o = drop_cnt_q;
`endif

   assign bus.valid_o     = valid_q;
   assign bus.iretire_o   = blk_q.iretire;
   assign bus.ilastsize_o = blk_q.ilastsize;
   assign bus.itype_o     = blk_q.itype;
   assign bus.cause_o     = blk_q.cause;
   assign bus.tval_o      = blk_q.tval;
   assign bus.priv_o      = blk_q.priv;
   assign bus.iaddr_o     = blk_q.iaddr;
   assign bus.block_idx_o = block_idx_q;
   assign bus.last_o      = last_q;
   assign bus.overflow_o  = overflow_q;

endmodule

// File: tb/tb_te_ingress_rx.sv
// Directed bench for te_ingress_rx: beat-queue reference model, per-cycle compare, literal spot checks.
module tb_te_ingress_rx;
   import mure_pkg::*;

   localparam int unsigned N     = 2;
   localparam int unsigned DEPTH = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   te_ingress_rx_if #(.N(N)) bus ();

`ifdef TE_INGRESS_DROP_CNT_EN
   logic        clr;
   logic [15:0] dcnt;
`endif

   te_ingress_rx #(.N(N), .DEPTH(DEPTH)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
`ifdef TE_INGRESS_DROP_CNT_EN
      .drop_cnt_clr_i (clr),
      .drop_cnt_o     (dcnt),
`endif
      .bus            (bus)
   );

   typedef struct {
      int unsigned idx;
      logic        last;
      te_block_t   blk;
   } beat_t;

   beat_t       exp_q[$];
   int unsigned m_nbund;
   logic        m_ovf;
   int unsigned m_cnt;
   bit          cmp_en;
   int          n_checks;
   int          n_errors;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic blk_ne(input te_block_t b);
      return (b.iretire != '0) || (b.itype != '0);
   endfunction

   function automatic te_block_t mk(input int unsigned ir, input int unsigned ty,
                                    input int unsigned ca, input logic [31:0] tv,
                                    input logic [31:0] ia);
      te_block_t b;
      b.iretire   = IRETIRE_LEN'(ir);
      b.ilastsize = ir[0];
      b.itype     = ITYPE_LEN'(ty);
      b.cause     = CAUSE_LEN'(ca);
      b.tval      = tv;
      b.priv      = PRIV_LEN'(ia[3:2]);
      b.iaddr     = ia;
      return b;
   endfunction

   task automatic drive(input logic v, input te_block_t b0, input te_block_t b1);
      te_block_t bb [N];
      bb[0] = b0;
      bb[1] = b1;
      bus.valid_i = v;
      for (int b = 0; b < N; b++) begin
         bus.iretire_i[b]   = bb[b].iretire;
         bus.ilastsize_i[b] = bb[b].ilastsize;
         bus.itype_i[b]     = bb[b].itype;
         bus.cause_i[b]     = bb[b].cause;
         bus.tval_i[b]      = bb[b].tval;
         bus.priv_i[b]      = bb[b].priv;
         bus.iaddr_i[b]     = bb[b].iaddr;
      end
   endtask

   task automatic idle();
      drive(1'b0, mk(0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0));
   endtask

   // Reference: a queue of pending beats; a bundle occupies a slot until its last beat leaves.
   task automatic model_step();
      te_block_t   in_b [N];
      logic        xfer, pop, anyne;
      int unsigned nb0, hi;
      beat_t       bt;
      if (rst) begin
         exp_q.delete();
         m_nbund = 0;
         m_ovf   = 1'b0;
         m_cnt   = 0;
      end else begin
         nb0   = m_nbund;
         xfer  = (exp_q.size() > 0) && bus.ready_i;
         pop   = xfer && exp_q[0].last;
         anyne = 1'b0;
         hi    = 0;
         for (int b = 0; b < N; b++) begin
            in_b[b].iretire   = bus.iretire_i[b];
            in_b[b].ilastsize = bus.ilastsize_i[b];
            in_b[b].itype     = bus.itype_i[b];
            in_b[b].cause     = bus.cause_i[b];
            in_b[b].tval      = bus.tval_i[b];
            in_b[b].priv      = bus.priv_i[b];
            in_b[b].iaddr     = bus.iaddr_i[b];
            if (blk_ne(in_b[b])) begin
               anyne = 1'b1;
               hi    = b;
            end
         end
         if (xfer) begin
            void'(exp_q.pop_front());
            if (pop) m_nbund--;
         end
         if (bus.valid_i && anyne) begin
            if ((nb0 < DEPTH) || pop) begin
               for (int b = 0; b < N; b++) begin
                  if (blk_ne(in_b[b])) begin
                     bt.idx  = b;
                     bt.last = (b == hi);
                     bt.blk  = in_b[b];
                     exp_q.push_back(bt);
                  end
               end
               m_nbund++;
            end else begin
               m_ovf = 1'b1;
               if (m_cnt < 65535) m_cnt++;
            end
         end
`ifdef TE_INGRESS_DROP_CNT_EN
         if (clr) m_cnt = 0;
`endif
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // Per-cycle comparison of every output against the model head.
   initial forever begin
      @(negedge clk);
      if (cmp_en) begin
         if (exp_q.size() > 0) begin
            chk("valid_o",     128'(bus.valid_o),     128'(1));
            chk("block_idx_o", 128'(bus.block_idx_o), 128'(exp_q[0].idx));
            chk("last_o",      128'(bus.last_o),      128'(exp_q[0].last));
            chk("iretire_o",   128'(bus.iretire_o),   128'(exp_q[0].blk.iretire));
            chk("ilastsize_o", 128'(bus.ilastsize_o), 128'(exp_q[0].blk.ilastsize));
            chk("itype_o",     128'(bus.itype_o),     128'(exp_q[0].blk.itype));
            chk("cause_o",     128'(bus.cause_o),     128'(exp_q[0].blk.cause));
            chk("tval_o",      128'(bus.tval_o),      128'(exp_q[0].blk.tval));
            chk("priv_o",      128'(bus.priv_o),      128'(exp_q[0].blk.priv));
            chk("iaddr_o",     128'(bus.iaddr_o),     128'(exp_q[0].blk.iaddr));
         end else begin
            chk("valid_o", 128'(bus.valid_o), 128'(0));
            chk("idle_zero", 128'({bus.iretire_o, bus.ilastsize_o, bus.itype_o, bus.cause_o,
                                   bus.tval_o, bus.priv_o, bus.iaddr_o, bus.block_idx_o,
                                   bus.last_o}), 128'(0));
         end
         chk("overflow_o", 128'(bus.overflow_o), 128'(m_ovf));
`ifdef TE_INGRESS_DROP_CNT_EN
         chk("drop_cnt_o", 128'(dcnt), 128'(m_cnt));
`endif
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic drain(input string name, input int unsigned exp_bundles);
      int unsigned lasts = 0;
      int          k     = 0;
      bus.ready_i = 1'b1;
      while (bus.valid_o && (k < 64)) begin
         if (bus.last_o) lasts++;
         @(negedge clk);
         k++;
      end
      chk({name, "_drained"}, 128'(bus.valid_o), 128'(0));
      chk({name, "_bundles"}, 128'(lasts), 128'(exp_bundles));
   endtask

   initial begin
      logic [23:0] pat;
      te_block_t   b0, b1;
      rst         = 1'b1;
      cmp_en      = 1'b0;
      n_checks    = 0;
      n_errors    = 0;
      bus.ready_i = 1'b1;
`ifdef TE_INGRESS_DROP_CNT_EN
      clr = 1'b0;
`endif
      idle();
      repeat (2) @(negedge clk);
      cmp_en = 1'b1;
      chk("rst_valid",    128'(bus.valid_o),     128'(0));
      chk("rst_overflow", 128'(bus.overflow_o),  128'(0));
      chk("rst_idx",      128'(bus.block_idx_o), 128'(0));
      chk("rst_last",     128'(bus.last_o),      128'(0));
      rst = 1'b0;

      // Two non-empty blocks, ready high
      drive(1'b1, mk(3, 0, 0, 0, 32'h8000_0000), mk(5, 0, 0, 0, 32'h8000_0010));
      @(negedge clk);
      idle();
      chk("t1_b0_valid", 128'(bus.valid_o),     128'(1));
      chk("t1_b0_idx",   128'(bus.block_idx_o), 128'(0));
      chk("t1_b0_last",  128'(bus.last_o),      128'(0));
      chk("t1_b0_iaddr", 128'(bus.iaddr_o),     128'(32'h8000_0000));
      @(negedge clk);
      chk("t1_b1_idx",   128'(bus.block_idx_o), 128'(1));
      chk("t1_b1_last",  128'(bus.last_o),      128'(1));
      chk("t1_b1_iret",  128'(bus.iretire_o),   128'(5));
      chk("t1_b1_iaddr", 128'(bus.iaddr_o),     128'(32'h8000_0010));
      @(negedge clk);
      chk("t1_done", 128'(bus.valid_o), 128'(0));

      // Block 0 empty, block 1 an exception
      drive(1'b1, mk(0, 0, 0, 0, 0), mk(0, 1, 2, 32'h0000_DEAD, 32'h8000_0020));
      @(negedge clk);
      idle();
      chk("t2_valid", 128'(bus.valid_o),     128'(1));
      chk("t2_idx",   128'(bus.block_idx_o), 128'(1));
      chk("t2_last",  128'(bus.last_o),      128'(1));
      chk("t2_cause", 128'(bus.cause_o),     128'(2));
      chk("t2_tval",  128'(bus.tval_o),      128'(32'h0000_DEAD));
      @(negedge clk);
      chk("t2_done", 128'(bus.valid_o), 128'(0));

      // All-empty bundle is discarded
      drive(1'b1, mk(0, 0, 7, 32'h1234, 32'h9000_0000), mk(0, 0, 3, 32'h5678, 32'h9000_0010));
      @(negedge clk);
      idle();
      chk("t3_valid",    128'(bus.valid_o),    128'(0));
      chk("t3_overflow", 128'(bus.overflow_o), 128'(0));
      @(negedge clk);

      // Five bundles against a stalled consumer: fifth is dropped
      bus.ready_i = 1'b0;
      for (int k = 0; k < 5; k++) begin
         drive(1'b1, mk(k + 1, 0, 0, 0, 32'h8000_1000 + 32'(k) * 16),
               (k % 2 == 1) ? mk(2, 0, 0, 0, 32'h8000_1008 + 32'(k) * 16) : mk(0, 0, 0, 0, 0));
         @(negedge clk);
      end
      idle();
      chk("t4_overflow", 128'(bus.overflow_o), 128'(1));
      chk("t4_head_idx", 128'(bus.block_idx_o), 128'(0));
      chk("t4_head_ir",  128'(bus.iretire_o),  128'(1));
      @(negedge clk);
      chk("t4_stall_ir", 128'(bus.iretire_o),  128'(1));
      drain("t4", 4);
      chk("t4_overflow_kept", 128'(bus.overflow_o), 128'(1));
`ifdef TE_INGRESS_DROP_CNT_EN
      chk("t4_drop_cnt", 128'(dcnt), 128'(1));
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("t4_drop_clr", 128'(dcnt), 128'(0));
`endif

      // Reset between the two beats of a bundle
      drive(1'b1, mk(4, 0, 0, 0, 32'h8000_3000), mk(6, 0, 0, 0, 32'h8000_3010));
      @(negedge clk);
      idle();
      chk("t6_pre_idx", 128'(bus.block_idx_o), 128'(0));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t6_rst_valid",    128'(bus.valid_o),    128'(0));
      chk("t6_rst_overflow", 128'(bus.overflow_o), 128'(0));
      drive(1'b1, mk(7, 0, 0, 0, 32'h8000_4000), mk(8, 0, 0, 0, 32'h8000_4010));
      @(negedge clk);
      idle();
      chk("t6_new_idx",  128'(bus.block_idx_o), 128'(0));
      chk("t6_new_iret", 128'(bus.iretire_o),   128'(7));
      @(negedge clk);
      chk("t6_new_idx1", 128'(bus.block_idx_o), 128'(1));
      @(negedge clk);
      chk("t6_done", 128'(bus.valid_o), 128'(0));

      // Full FIFO: push coinciding with the last-block transfer is accepted
      bus.ready_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, mk(0, 0, 0, 0, 0), mk(k + 10, 0, 0, 0, 32'h8000_5000 + 32'(k) * 16));
         @(negedge clk);
      end
      bus.ready_i = 1'b1;
      drive(1'b1, mk(20, 0, 0, 0, 32'h8000_6000), mk(0, 0, 0, 0, 0));
      @(negedge clk);
      idle();
      bus.ready_i = 1'b0;
      chk("t5_overflow", 128'(bus.overflow_o), 128'(0));
      chk("t5_head_ir",  128'(bus.iretire_o),  128'(11));
      drive(1'b1, mk(21, 0, 0, 0, 32'h8000_7000), mk(0, 0, 0, 0, 0));
      @(negedge clk);
      idle();
      chk("t5_still_full", 128'(bus.overflow_o), 128'(1));
      drain("t5", 4);

      // Mixed bundles against an intermittent consumer
      pat = 24'b1101_0110_1110_0101_1011_0111;
      for (int i = 0; i < 24; i++) begin
         bus.ready_i = pat[i];
         if (i < 10) begin
            b0 = (i % 3 == 0) ? mk(0, 0, 0, 0, 0)
                              : mk(i + 1, i % 4, i, 32'h0000_A000 + 32'(i), 32'h8000_2000 + 32'(i) * 32);
            b1 = (i % 4 == 1) ? mk(0, 0, 0, 0, 0)
                              : mk(i % 2, (i % 3) + 1, i + 3, 32'h0000_B000 + 32'(i), 32'h8000_2010 + 32'(i) * 32);
            drive(1'b1, b0, b1);
         end else begin
            idle();
         end
         @(negedge clk);
      end
      idle();
      drain("t7", 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
